// File: rtl/register_bank_pkg.sv
// Shared sizing and types for the register file.
// Zero latency; no backpressure (pure definitions).
package register_bank_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 32;
  localparam int ZERO_REG   = 0;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;
endpackage

// File: rtl/register_bank_read_port.sv
// One combinational read port: index mux, r0 forced to zero, optional write bypass.
// Zero latency; no backpressure (always ready).
module register_bank_read_port
  import register_bank_pkg::*;
#(
  parameter int DATA_WIDTH = register_bank_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = register_bank_pkg::ADDR_WIDTH
) (
  input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] mem,
  input  logic [ADDR_WIDTH-1:0]                      rd_addr,
`ifdef REGISTER_BANK_BYPASS_EN
  input  logic                                       byp_vld,
  input  logic [ADDR_WIDTH-1:0]                      byp_addr,
  input  logic [DATA_WIDTH-1:0]                      byp_dat,
`endif
  output logic [DATA_WIDTH-1:0]                      rd_dat
);

  always_comb begin
    rd_dat = mem[rd_addr];
    if (rd_addr == ADDR_WIDTH'(ZERO_REG)) begin
      rd_dat = '0;
    end
`ifdef REGISTER_BANK_BYPASS_EN
    // Forward the in-flight write-back value so decode sees it this cycle.
    if (byp_vld && (byp_addr != ADDR_WIDTH'(ZERO_REG)) && (byp_addr == rd_addr)) begin
      rd_dat = byp_dat;
    end
`endif
  end

endmodule

// File: rtl/register_bank.sv
// 32x32 register file, 2 async read ports, 1 sync write port; r0 reads zero. Optional macro REGISTER_BANK_BYPASS_EN.
// Read latency 0, write visible after the edge; no backpressure (writes always accepted).
module register_bank
  import register_bank_pkg::*;
#(
  parameter int DATA_WIDTH = register_bank_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = register_bank_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] i_r1,
  input  logic [ADDR_WIDTH-1:0] i_r2,
  input  logic [ADDR_WIDTH-1:0] write_register,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  regwrite,
  output logic [DATA_WIDTH-1:0] d1,
  output logic [DATA_WIDTH-1:0] d2
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (regwrite && (write_register != ADDR_WIDTH'(ZERO_REG))) begin
      mem_d[write_register] = write_data;
    end
  end

  // Reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

`ifdef REGISTER_BANK_BYPASS_EN
  logic byp_vld;
  assign byp_vld = regwrite & ~reset;
`endif

  register_bank_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd1 (
    .mem      (mem_q),
    .rd_addr  (i_r1),
`ifdef REGISTER_BANK_BYPASS_EN
    .byp_vld  (byp_vld),
    .byp_addr (write_register),
    .byp_dat  (write_data),
`endif
    .rd_dat   (d1)
  );

  register_bank_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd2 (
    .mem      (mem_q),
    .rd_addr  (i_r2),
`ifdef REGISTER_BANK_BYPASS_EN
    .byp_vld  (byp_vld),
    .byp_addr (write_register),
    .byp_dat  (write_data),
`endif
    .rd_dat   (d2)
  );

endmodule

// File: tb/tb_register_bank.sv
// Directed plus randomized bench for register_bank against an array-based reference model.
// Honours REGISTER_BANK_BYPASS_EN for the same-cycle read expectation.
module tb_register_bank;
  import register_bank_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  i_r1, i_r2, write_register;
  logic [31:0] write_data;
  logic        regwrite;
  logic [31:0] d1, d2;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [NUM_REGS];

  register_bank dut (
    .clk            (clk),
    .reset          (reset),
    .i_r1           (i_r1),
    .i_r2           (i_r2),
    .write_register (write_register),
    .write_data     (write_data),
    .regwrite       (regwrite),
    .d1             (d1),
    .d2             (d2)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
    reset = rst; regwrite = we; write_register = wa; write_data = wd;
    i_r1 = r1; i_r2 = r2;
  endtask

  // Expected combinational read given the stored model and the write currently presented.
  function automatic logic [31:0] model_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef REGISTER_BANK_BYPASS_EN
    if (regwrite === 1'b1 && reset === 1'b0 && write_register == a) return write_data;
`endif
    return model[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
    end else if (regwrite && write_register != 5'd0) begin
      model[write_register] = write_data;
    end
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ports(input string tag);
    #1;
    check({tag, "_d1"}, d1, model_rd(i_r1));
    check({tag, "_d2"}, d2, model_rd(i_r2));
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) model[i] = 32'hX;

    // Reset together with a write: the write must be discarded.
    drive(1'b1, 1'b1, 5'd7, $urandom, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      i_r1 = 5'(i); i_r2 = 5'(31 - i);
      #1;
      check("reset_d1", d1, 32'h0);
      check("reset_d2", d2, 32'h0);
    end

    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    #1;
    check("wr_r5_d1", d1, 32'hDEADBEEF);
    check("wr_r5_d2", d2, 32'hDEADBEEF);

    drive(1'b0, 1'b1, 5'd31, 32'h12345678, 5'd5, 5'd5);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
    #1;
    check("wr_r31_d2", d2, 32'h12345678);

    drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    #1;
    check("r0_same_cycle_d1", d1, 32'h0);
    tick();
    regwrite = 1'b0;
    #1;
    check("r0_protect_d1", d1, 32'h0);

    drive(1'b0, 1'b1, 5'd7, 32'h0BADF00D, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 5'd7, 32'hAAAA5555, 5'd7, 5'd0);
    tick();
    check("we_gate_r7", d1, 32'h0BADF00D);

    drive(1'b1, 1'b1, 5'd7, 32'hCAFEF00D, 5'd7, 5'd5);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd5);
    #1;
    check("rst_prio_r7", d1, 32'h0);
    check("rst_clears_r5", d2, 32'h0);

    drive(1'b0, 1'b1, 5'd3, 32'h00000003, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b1, 5'd4, 32'h00000004, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
    #1;
    check("dual_d1", d1, 32'h3);
    check("dual_d2", d2, 32'h4);
    i_r1 = 5'd4; i_r2 = 5'd3;
    #1;
    check("swap_d1", d1, 32'h4);
    check("swap_d2", d2, 32'h3);

    drive(1'b0, 1'b1, 5'd9, 32'h11111111, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b1, 5'd9, 32'h22222222, 5'd9, 5'd9);
    #1;
`ifdef REGISTER_BANK_BYPASS_EN
    check("hazard_pre_d1", d1, 32'h22222222);
`else
    check("hazard_pre_d1", d1, 32'h11111111);
`endif
    tick();
    check("hazard_post_d1", d1, 32'h22222222);
    regwrite = 1'b0;
    #1;
    check("hazard_stored_d2", d2, 32'h22222222);

    // Random traffic: biased toward writes, rare resets, frequent address collisions.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa, r1, r2;
      wa = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), wa, $urandom, r1, r2);
      check_ports("rand");
      tick();
    end
    regwrite = 1'b0; reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      i_r1 = 5'(i); i_r2 = 5'(i ^ 5'h1f);
      check_ports("final");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- General-purpose register file for the TPFinal MIPS-style datapath.
- 32 registers x 32 bits, two asynchronous read ports, one synchronous write port.
- Register 0 is hardwired to zero.
- Read in the decode stage; written from the write-back stage.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, register-index width; depth = 2**ADDR_WIDTH = 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- i_r1  input  ADDR_WIDTH  read address, port 1 (rs).
- i_r2  input  ADDR_WIDTH  read address, port 2 (rt).
- write_register  input  ADDR_WIDTH  write address (rd/rt from write-back).
- write_data  input  DATA_WIDTH  write data.
- regwrite  input  1  write enable.
- d1  output  DATA_WIDTH  read data for i_r1.
- d2  output  DATA_WIDTH  read data for i_r2.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Storage: 32 x DATA_WIDTH flops, no memory macro.
- Reset: on a rising edge with reset=1, all 32 registers clear to 0. Reset has priority over a simultaneous write; that write is discarded.
- After reset, with no writes, d1=d2=0 for any address.
- Write: on a rising edge with reset=0 and regwrite=1, mem[write_register] <= write_data.
  - write_register=0: write ignored; mem[0] stays 0.
  - regwrite=0: no state change.
- Read: fully combinational, zero latency. d1 = mem[i_r1] and d2 = mem[i_r2], changing within the same cycle as the addresses.
  - Address 0 always reads 0.
- Both read ports are independent. i_r1 == i_r2 is legal, and both outputs then show the same value.
- Write-then-read timing, without the optional feature: data written on edge N is visible on d1/d2 immediately after edge N.
- Same-cycle write and read of one address (see Optional Feature):
  - Feature absent: outputs show the old value until the edge.
- Outputs are never X after the first reset. Before the first reset, contents are undefined.

Optional Feature:
- Macro: REGISTER_BANK_BYPASS_EN.
- Defined: internal write-to-read forwarding.
  - If regwrite=1, reset=0, write_register != 0 and write_register == i_r1, then d1 = write_data combinationally in the same cycle. The same rule applies independently to d2/i_r2.
  - Resolves the WB/ID hazard for a pipeline that writes and reads in the same cycle.
  - Address 0 is never bypassed.
- Undefined: no forwarding; reads return stored contents only.

Decomposition:
- Shared package (register_bank_pkg):
  - DATA_WIDTH and ADDR_WIDTH defaults.
  - NUM_REGS = 32.
  - ZERO_REG = 0.
  - typedef reg_addr_t (ADDR_WIDTH bits) and reg_data_t (DATA_WIDTH bits).
- Sub-module register_bank_read_port:
  - Instantiated twice.
  - Contains the address decode/mux, the r0 zero-forcing, and the macro-guarded bypass compare.
- Top level holds the storage array and the write/reset logic.

Test Plan:
- Reset: reset=1 for one edge, then read i_r1=0..31 and i_r2=31..0 -> d1=d2=0 for every address.
- Basic write/read: write 0xDEADBEEF to r5 with regwrite=1, then i_r1=5, i_r2=5 -> d1=d2=0xDEADBEEF. Also write 0x12345678 to r31, then i_r2=31 -> 0x12345678.
- r0 protection: write 0xFFFFFFFF to r0 -> d1 with i_r1=0 reads 0x00000000.
- Enable gating and priority:
  - regwrite=0 with write_register=7, write_data=0xAAAA5555 -> r7 stays at its prior value.
  - reset=1 together with regwrite=1 to r7 -> r7=0 after the edge.
- Dual independent reads: r3=0x00000003 and r4=0x00000004, then i_r1=3, i_r2=4 -> d1=3, d2=4. Swap addresses -> outputs swap in the same cycle.
- Same-cycle hazard: r9=0x11111111, then drive regwrite=1, write_register=9, write_data=0x22222222, i_r1=9 before the edge.
  - With REGISTER_BANK_BYPASS_EN: d1=0x22222222 before the edge.
  - Without the macro: d1=0x11111111 before the edge.
  - Both builds: d1=0x22222222 after the edge.
